sc_bitstream_decoder: RTL and testbench

Serial stochastic-bitstream decoder: counts the ones in each window of BITSTREAM valid input bits and converts the count back to a QUANT-bit signed sample. It is the receive-side inverse of the quota encoder, which maps a quantized value to a number of ones per BITSTREAM-bit window. The decoder sits after the stochastic compute fabric and returns results to the binary datapath through a valid/ready output with a one-entry buffer.

---
 rtl/sc_bitstream_decoder.sv | 117 +++++++++++
 tb/tb_sc_bitstream_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_bitstream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sc_bitstream_decoder
// Description : Stochastic-bitstream receiver. Counts the ones in each window
//               of BITSTREAM accepted bits and converts that count back into a
//               QUANT-bit two's-complement sample, presented on a valid/ready
//               output through a one-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_bitstream_decoder #(
    parameter int  BITSTREAM = 64,
    parameter int  QUANT     = 8,
    localparam int c_L       = $clog2(BITSTREAM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QUANT-1:0] out_data,
    output logic [c_L:0]     out_quota
);

    localparam int             c_SHIFT = QUANT - c_L;
    localparam logic [c_L-1:0] c_LAST  = c_L'(BITSTREAM - 1);
    localparam logic [c_L:0]   c_FULL  = (c_L + 1)'(BITSTREAM);

    // Buffer flag states: ACCUM = output empty, HOLD = frame presented.
    localparam logic [0:0] c_ACCUM = 1'b0;
    localparam logic [0:0] c_HOLD  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [c_L-1:0]   r_bit_idx;
    logic [c_L:0]     r_ones;
    logic [QUANT-1:0] r_out_data;
    logic [c_L:0]     r_out_quota;

    logic             w_last;
    logic             w_accept;
    logic             w_complete;
    logic [c_L:0]     w_total;
    logic [QUANT-1:0] w_v;

    assign w_last     = (r_bit_idx == c_LAST);
    // Only the closing bit of a frame can stall: it would overwrite a frame
    // that downstream has not yet taken.
    assign bit_ready  = !(w_last && (r_state == c_HOLD) && !out_ready);
    assign w_accept   = bit_valid && bit_ready;
    assign w_complete = w_accept && w_last;
    assign w_total    = r_ones + (c_L + 1)'(bit_in);

    // Scale the ones count up to sample width; a full window of ones would
    // land one past the top code, so it saturates to all ones instead.
    always_comb begin
        w_v = QUANT'(w_total) << c_SHIFT;
        if (w_total == c_FULL) begin
            w_v = '1;
        end
    end

    // Buffer flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer flag next state: a completing frame always (re)loads the
    // buffer, otherwise a consume empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_complete) begin
            w_state_nxt = c_HOLD;
        end else if ((r_state == c_HOLD) && out_ready) begin
            w_state_nxt = c_ACCUM;
        end
    end

    // Window position and ones accumulator; both restart on frame completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx <= '0;
            r_ones    <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_bit_idx <= '0;
                r_ones    <= '0;
            end else begin
                r_bit_idx <= r_bit_idx + c_L'(1);
                r_ones    <= w_total;
            end
        end
    end

    // Output buffer: loads only on completion, so it holds under backpressure.
    // Flipping the MSB turns the offset-binary code into two's complement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_quota <= '0;
        end else if (w_complete) begin
            r_out_data  <= {~w_v[QUANT-1], w_v[QUANT-2:0]};
            r_out_quota <= w_total;
        end
    end

    assign out_valid = (r_state == c_HOLD);
    assign out_data  = r_out_data;
    assign out_quota = r_out_quota;

endmodule
`default_nettype wire

// File: tb/tb_sc_bitstream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_bitstream_decoder
// Description : Self-checking bench for sc_bitstream_decoder. Stimulus feeds a
//               window-counting reference model that queues expected frames;
//               an independent monitor compares every consumed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_bitstream_decoder;

    localparam int BITSTREAM = 64;
    localparam int QUANT     = 8;
    localparam int L         = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             out_valid;
    logic             out_ready;
    logic [QUANT-1:0] out_data;
    logic [L:0]       out_quota;

    typedef struct packed {
        logic [L:0]       quota;
        logic [QUANT-1:0] data;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               errors    = 0;
    int               checks    = 0;
    int               stalls    = 0;
    int               m_idx     = 0;
    int               m_ones    = 0;
    bit               rt_mode   = 1'b0;
    logic [QUANT-1:0] rt_expect = '0;

    sc_bitstream_decoder #(
        .BITSTREAM (BITSTREAM),
        .QUANT     (QUANT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_quota (out_quota)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Sample value for a window holding q ones: each one is worth 2^(QUANT-L)
    // LSBs above the most negative code, clamped at the most positive code.
    function automatic logic [QUANT-1:0] ref_decode(input int q);
        int d;
        d = q * (1 << (QUANT - L)) - (1 << (QUANT - 1));
        if (d > (1 << (QUANT - 1)) - 1) d = (1 << (QUANT - 1)) - 1;
        return d[QUANT-1:0];
    endfunction

    function automatic logic [63:0] rand_bits(input int n, input int width);
        logic [63:0] v;
        int placed;
        v = '0;
        placed = 0;
        while (placed < n) begin
            int p;
            p = int'($urandom_range(width - 1));
            if (!v[p]) begin
                v[p] = 1'b1;
                placed++;
            end
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference model: one accepted bit; a full window queues its frame.
    task automatic model_accept(input logic b);
        m_ones += int'(b);
        m_idx++;
        if (m_idx == BITSTREAM) begin
            exp_t e;
            e.quota = (L + 1)'(m_ones);
            e.data  = rt_mode ? rt_expect : ref_decode(m_ones);
            sb_q.push_back(e);
            m_idx  = 0;
            m_ones = 0;
        end
    endtask

    // Called and returns at posedge+1; offers one bit until it is accepted.
    task automatic drive_bit(input logic b);
        int waited;
        bit ok;
        waited    = 0;
        ok        = 1'b0;
        bit_valid = 1'b1;
        bit_in    = b;
        while (!ok) begin
            @(negedge clk);
            if (bit_ready === 1'b1) begin
                ok = 1'b1;
            end else begin
                stalls++;
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL bit_ready_timeout: bit_ready=%b after %0d cycles, required 1", bit_ready, waited);
                    break;
                end
            end
        end
        if (ok) begin
            @(posedge clk);
            model_accept(b);
        end
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [63:0] v, input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) idle(1);
            drive_bit(v[i]);
        end
    endtask

    // Scoreboard monitor: each frame is compared on the cycle it is consumed.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got quota=%0d data=0x%02h, required no frame", out_quota, out_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (out_quota !== mon_e.quota || out_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL sb_frame: got quota=%0d data=0x%02h, required quota=%0d data=0x%02h",
                             out_quota, out_data, mon_e.quota, mon_e.data);
                end
            end
        end
    end

    initial begin
        logic [63:0] f1;
        logic [63:0] f2;

        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_quota", 32'(out_quota), 0);
        check("rst_bit_ready", 32'(bit_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All ones: saturated sample, valid for exactly one cycle.
        for (int i = 0; i < BITSTREAM - 1; i++) drive_bit(1'b1);
        @(negedge clk);
        check("t1_no_early_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        drive_bit(1'b1);
        @(negedge clk);
        check("t1_valid_latency", 32'(out_valid), 1);
        check("t1_quota", 32'(out_quota), 64);
        check("t1_data", 32'(out_data), 32'h7F);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        // All zeros then alternating, back to back.
        stalls = 0;
        for (int i = 0; i < BITSTREAM; i++) drive_bit(1'b0);
        for (int i = 0; i < BITSTREAM; i++) drive_bit(((i % 2) == 0) ? 1'b1 : 1'b0);
        check("t2_no_bubble", 32'(stalls), 0);

        // Sixteen scattered ones with random input gaps.
        f1 = rand_bits(16, 64);
        drive_frame(f1, BITSTREAM, 30);
        idle(2);

        // Backpressure on the closing bit while a frame is held.
        out_ready = 1'b0;
        f1 = rand_bits(20, 64);
        drive_frame(f1, BITSTREAM, 0);
        f2 = rand_bits(47, 63);
        f2[63] = 1'b1;
        drive_frame(f2, BITSTREAM - 1, 0);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t4_stall_ready", 32'(bit_ready), 0);
            check("t4_hold_valid", 32'(out_valid), 1);
            check("t4_hold_quota", 32'(out_quota), 20);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_bit(1'b1);
        @(negedge clk);
        check("t4_valid_stays", 32'(out_valid), 1);
        check("t4_replace_data", 32'(out_data), 32'h40);
        @(posedge clk);
        #1;

        // Reset mid-frame with a frame still buffered.
        out_ready = 1'b0;
        f1 = rand_bits(37, 64);
        drive_frame(f1, BITSTREAM, 0);
        f1 = rand_bits(25, 64);
        drive_frame(f1, 40, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_out_valid", 32'(out_valid), 0);
        check("t5_out_data", 32'(out_data), 0);
        check("t5_out_quota", 32'(out_quota), 0);
        check("t5_bit_ready", 32'(bit_ready), 1);
        sb_q.delete();
        m_idx  = 0;
        m_ones = 0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        f1 = rand_bits(10, 64);
        drive_frame(f1, BITSTREAM, 0);
        idle(2);

        // Round trip through the quota encoder for every sample value.
        rt_mode = 1'b1;
        for (int s = -128; s < 128; s++) begin
            int q;
            q = (s + 128) >> (QUANT - L);
            rt_expect = QUANT'(s & ~3);
            f1 = rand_bits(q, 64);
            drive_frame(f1, BITSTREAM, 0);
        end
        rt_mode = 1'b0;

        idle(4);
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
